// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: line synchroniser, start detect, 3-point majority bit sampling,
// frame tracking with parity/stop checks. Optional build macro: START_GLITCH_CHECK_EN.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | inside start bit
//   DATA   | inside data bit bit_cnt, one deser_en per bit
//   PARITY | inside parity bit
//   STOP   | inside stop bit, leaves at its decision edge
module uart_rx_bit_sampler #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  sampled_data,
    output logic                  deser_en,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  frame_done,
    output logic                  data_valid,
    output logic                  busy
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(8);
    localparam logic [BIT_W-1:0]      LAST_BIT     = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_meta, rx_s;
    logic [PRESCALE_W-1:0] edge_cnt, presc_q, mid;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_q, par_typ_q, parity_acc;
    logic                  s0, s1, s2, maj;
    logic                  start_det, at_wrap, at_dec, last_bit, glitch_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign mid       = presc_q >> 1;
    assign start_det = (state_q == IDLE) && !rx_s;
    assign at_wrap   = (edge_cnt == presc_q - PRESCALE_W'(1));
    assign at_dec    = (edge_cnt == mid + PRESCALE_W'(2));
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign maj       = (s0 & s1) | (s0 & s2) | (s1 & s2);
    assign busy      = (state_q != IDLE);

`ifdef START_GLITCH_CHECK_EN
    assign glitch_abort = (state_q == START) && at_dec && maj;
`else
    assign glitch_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START: begin
                if (glitch_abort) state_d = IDLE;
                else if (at_wrap) state_d = DATA;
            end
            DATA:    if (at_wrap && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (at_wrap) state_d = STOP;
            STOP:    if (at_dec) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The start-detect cycle counts as edge 0 of the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_det) begin
            edge_cnt <= PRESCALE_W'(1);
            bit_cnt  <= '0;
        end else if (state_q == IDLE || state_d == IDLE || at_wrap) begin
            edge_cnt <= '0;
            if (state_q == DATA && at_wrap && !last_bit) bit_cnt <= bit_cnt + BIT_W'(1);
            else if (state_q != DATA || state_d != DATA) bit_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= MIN_PRESCALE;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            parity_acc   <= 1'b0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            s2           <= 1'b1;
            sampled_data <= 1'b1;
            deser_en     <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            frame_done   <= 1'b0;
            data_valid   <= 1'b0;
        end else begin
            deser_en   <= 1'b0;
            frame_done <= 1'b0;
            data_valid <= 1'b0;
            if (start_det) begin
                presc_q    <= (prescale < MIN_PRESCALE) ? MIN_PRESCALE : prescale;
                par_en_q   <= par_en;
                par_typ_q  <= par_typ;
                parity_acc <= 1'b0;
                par_err    <= 1'b0;
                stp_err    <= 1'b0;
            end
            if (state_q != IDLE) begin
                if (edge_cnt == mid - PRESCALE_W'(1)) s0 <= rx_s;
                if (edge_cnt == mid)                  s1 <= rx_s;
                if (edge_cnt == mid + PRESCALE_W'(1)) s2 <= rx_s;
                if (at_dec) begin
                    sampled_data <= maj;
                    case (state_q)
                        DATA: begin
                            deser_en   <= 1'b1;
                            parity_acc <= parity_acc ^ maj;
                        end
                        PARITY: par_err <= maj ^ parity_acc ^ par_typ_q;
                        STOP: begin
                            stp_err    <= !maj;
                            frame_done <= 1'b1;
                            data_valid <= !par_err && maj;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
